sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single byte-addressed 64 KiB SRAM port between the instruction-fetch (IF) requester and the load/store (DM) requester.
- Handles arbitration, the request/grant/response handshake, and byte-enable generation for SB/SH/SW.
- Handles load extraction with sign or zero extension, and misaligned or illegal access detection.
- Sits between the pipeline fetch/MEM stages and the SRAM. It drives SRAM w_en/address/write_data from registers and samples SRAM read_data, which is combinational.

Parameters:
- ADDR_W, 16, byte address width; must match the SRAM address.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  input  1  system clock; the SRAM writes on its falling edge.
- rst_n  input  1  reset: asynchronous, active-low.
- if_req  input  1  IF read request; held until granted.
- if_addr  input  ADDR_W  IF byte address; word-aligned is required.
- if_gnt  output  1  IF request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  32  fetched word.
- if_err  output  1  qualifies if_rvalid: misaligned fetch.
- dm_req  input  1  DM request; held with its command until granted.
- dm_we  input  1  1 = store, 0 = load.
- dm_funct3  input  3  RV32I load/store funct3.
- dm_addr  input  ADDR_W  DM byte address.
- dm_wdata  input  32  store data, right-justified.
- dm_gnt  output  1  DM request accepted this cycle.
- dm_rvalid  output  1  one-cycle pulse: load data or store ack.
- dm_rdata  output  32  extended load data; 0 for stores.
- dm_err  output  1  qualifies dm_rvalid: misaligned or illegal funct3.
- sram_w_en  output  4  byte write enables to the SRAM.
- sram_addr  output  ADDR_W  SRAM byte address.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM combinational read data.

Behaviour:
- Reset values:
  - All outputs are 0.
  - state = IDLE.
  - last_served = IF, so DM wins the first tie.
  - Internal command registers are cleared.
- FSM states: IDLE and ACCESS.
- Granting:
  - Grants are combinational and occur only in IDLE.
  - If exactly one requester is active, grant it.
  - If both are active, grant the one not equal to last_served (round-robin).
  - At most one gnt is high per cycle.
- On the posedge where a gnt is high:
  - Latch the owner, address, we, funct3 and wdata.
  - Compute the error condition.
  - Update last_served.
  - Go to ACCESS.
- ACCESS, no error:
  - sram_addr = latched address.
  - sram_wdata = latched wdata.
  - sram_w_en: SB = 0001, SH = 0011, SW = 1111; loads and IF = 0000.
  - All SRAM outputs come from registers, so they are stable at the falling edge.
- ACCESS, error: sram_w_en = 0000, so there are no side effects.
- End of ACCESS (posedge):
  - Capture the response into the owner's rdata register.
  - Pulse the owner's rvalid for exactly the next cycle.
  - Return to IDLE.
  - A new grant may occur in that same IDLE cycle, giving a throughput of 1 access per 2 cycles.
- Latency: gnt in cycle N, SRAM access in cycle N+1, rvalid in cycle N+2.
- Load extraction from sram_rdata:
  - 000 LB: sign-extend [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: [31:0].
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
- Errors:
  - Illegal load funct3: 011, 110, 111.
  - Illegal store funct3: anything other than 000, 001, 010.
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 00; IF with if_addr[1:0] != 00.
  - On error: rvalid still pulses, err = 1, rdata = 0.
- err and rdata hold their value until the next response to the same port. rvalid is the only qualifier.
- Stores: dm_rvalid pulses as an ack with dm_rdata = 0.
- Address wrap: the SRAM wraps address+k modulo 2^16. The arbiter does not check for it, because aligned accesses never wrap.
- Request changes: a requester that drops req before being granted is simply not served. Any change to the command while req is held and ungranted is sampled at grant time.
- Reset asserted mid-ACCESS: sram_w_en clears to 0 asynchronously, the access is abandoned, no rvalid is issued, and last_served returns to IF.

Test Plan:
- Reset, then DM SW 0xDEADBEEF @0x0100 → dm_gnt in cycle 0, sram_w_en = 1111 in cycle 1, dm_rvalid = 1 and dm_err = 0 in cycle 2. IF read @0x0100 then returns 0xDEADBEEF 2 cycles after if_gnt.
- Following the previous store, SB 0x7F @0x0101, then LB/LBU @0x0101 and LH @0x0100 → 0x0000007F / 0x0000007F / 0x00007FEF. SB 0x80 @0x0102, then LB → 0xFFFFFF80, LBU → 0x00000080.
- if_req and dm_req held high together for 8 cycles after reset → grants DM, IF, DM, IF, one every 2 cycles. Never both gnt in the same cycle.
- LH @0x0203, SW @0x0202, and load with funct3 = 011 → each gives dm_rvalid with dm_err = 1 and dm_rdata = 0. sram_w_en stays 0000 throughout, and memory at 0x0200–0x0205 is unchanged.
- IF fetch @0x0006 → if_rvalid with if_err = 1. A subsequent fetch @0x0008 → if_err = 0 with the correct word.
- Assert rst_n = 0 during the ACCESS cycle of SW @0x0300 → sram_w_en drops to 0 immediately, no dm_rvalid, memory at 0x0300 is unchanged. After release, the next tie is granted to DM.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the arbiter and the SRAM.
//
// Handshake: a requester raises *_req with its command and holds both until
// it sees *_gnt high at the end of a cycle. Request and grant together
// transfer the command. Exactly one *_rvalid pulse answers each granted
// request. *_err and *_rdata are meaningful only while that pulse is high,
// and they hold their value until the next response on the same port.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    // Load/store port
    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              dm_err;

    // SRAM side
    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    // Arbiter FSM state: 0 = IDLE, 1 = ACCESS
    logic              arb_state;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output sram_w_en, sram_addr, sram_wdata,
        input  sram_rdata,
        output arb_state
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  sram_w_en, sram_addr, sram_wdata,
        output sram_rdata,
        input  arb_state
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the shared 64 KiB byte-addressed SRAM.
// The IF and DM ports are served round-robin at one access per two cycles:
// the grant happens in IDLE, the SRAM is driven from registers in ACCESS,
// and the response pulses in the following cycle.
module sram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_t              state_q, state_d;
    logic                last_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic [3:0]          wen_q;

    logic                if_gnt_c, dm_gnt_c;
    logic                dm_err_c, if_err_c;
    logic [3:0]          dm_wen_c;
    logic [DATA_W-1:0]   resp_c;

    logic                if_rvalid_q, dm_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic                if_err_q, dm_err_q;

    // Illegal funct3 for the direction, or an address not aligned to the size.
    function automatic logic dm_cmd_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = a[0];
            3'b010:  e = (a != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Lane enables for a legal store; lane 0 is the byte at the address.
    function automatic logic [3:0] store_wen(input logic [2:0] f3);
        logic [3:0] w;
        case (f3)
            3'b000:  w = 4'b0001;
            3'b001:  w = 4'b0011;
            3'b010:  w = 4'b1111;
            default: w = 4'b0000;
        endcase
        return w;
    endfunction

    // The SRAM returns the addressed byte in [7:0], so no lane shifting is needed.
    function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3,
                                                       input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d;
            3'b100:  r = {24'd0, d[7:0]};
            3'b101:  r = {16'd0, d[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Next state and grants: grant only in IDLE, round-robin on a tie.
    always_comb begin
        if_gnt_c = 1'b0;
        dm_gnt_c = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (bus.if_req && bus.dm_req) begin
                        if (last_q == OWN_IF) dm_gnt_c = 1'b1;
                        else                  if_gnt_c = 1'b1;
                    end else if (bus.dm_req) begin
                        dm_gnt_c = 1'b1;
                    end else if (bus.if_req) begin
                        if_gnt_c = 1'b1;
                    end
                end
                if (if_gnt_c || dm_gnt_c) state_d = ACCESS;
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Error and write-enable decode of the command being granted.
    always_comb begin
        dm_err_c = dm_cmd_err(bus.dm_we, bus.dm_funct3, bus.dm_addr[1:0]);
        if_err_c = (bus.if_addr[1:0] != 2'b00);
        dm_wen_c = (bus.dm_we && !dm_err_c) ? store_wen(bus.dm_funct3) : 4'b0000;
    end

    // Response word: zero on error or for a store ack.
    always_comb begin
        resp_c = '0;
        if (!err_q) begin
            if (owner_q == OWN_IF) resp_c = bus.sram_rdata;
            else if (!we_q)        resp_c = load_extract(f3_q, bus.sram_rdata);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Command latch at grant; write enables drop again at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= OWN_IF;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 4'b0000;
        end else if (dm_gnt_c) begin
            last_q  <= OWN_DM;
            owner_q <= OWN_DM;
            addr_q  <= bus.dm_addr;
            we_q    <= bus.dm_we;
            f3_q    <= bus.dm_funct3;
            wdata_q <= bus.dm_wdata;
            err_q   <= dm_err_c;
            wen_q   <= dm_wen_c;
        end else if (if_gnt_c) begin
            last_q  <= OWN_IF;
            owner_q <= OWN_IF;
            addr_q  <= bus.if_addr;
            we_q    <= 1'b0;
            f3_q    <= 3'b010;
            wdata_q <= '0;
            err_q   <= if_err_c;
            wen_q   <= 4'b0000;
        end else if (state_q == ACCESS) begin
            wen_q   <= 4'b0000;
        end
    end

    // Response capture at the end of ACCESS into the owner's registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            dm_err_q    <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if (state_q == ACCESS) begin
                if (owner_q == OWN_IF) begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= resp_c;
                    if_err_q    <= err_q;
                end else begin
                    dm_rvalid_q <= 1'b1;
                    dm_rdata_q  <= resp_c;
                    dm_err_q    <= err_q;
                end
            end
        end
    end

    assign bus.if_gnt     = if_gnt_c;
    assign bus.dm_gnt     = dm_gnt_c;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_err     = if_err_q;
    assign bus.dm_rvalid  = dm_rvalid_q;
    assign bus.dm_rdata   = dm_rdata_q;
    assign bus.dm_err     = dm_err_q;
    assign bus.sram_w_en  = wen_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.arb_state  = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural byte SRAM
// (falling-edge write, combinational read).
module tb_sram_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sram_port_arbiter_if #(.ADDR_W(16)) bus ();

    sram_port_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [7:0] mem [0:65535];

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (bus.sram_w_en[k]) mem[bus.sram_addr + 16'(k)] <= bus.sram_wdata[8*k +: 8];
    end

    always_comb begin
        bus.sram_rdata = {mem[bus.sram_addr + 16'd3], mem[bus.sram_addr + 16'd2],
                          mem[bus.sram_addr + 16'd1], mem[bus.sram_addr]};
    end

    // ---------------- vectors ----------------
    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wen;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_dm(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wen,
                          input logic [31:0] rdata, input logic err);
        vec_t v;
        v = '{is_dm: 1'b1, we: we, f3: f3, addr: addr, wdata: wdata,
              exp_wen: wen, exp_rdata: rdata, exp_err: err};
        vecs.push_back(v);
    endtask

    task automatic add_if(input logic [15:0] addr, input logic [31:0] rdata, input logic err);
        vec_t v;
        v = '{is_dm: 1'b0, we: 1'b0, f3: 3'b010, addr: addr, wdata: 32'd0,
              exp_wen: 4'b0000, exp_rdata: rdata, exp_err: err};
        vecs.push_back(v);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drop_reqs();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drop_reqs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One full transaction: grant in N, SRAM access in N+1, rvalid in N+2, low in N+3.
    task automatic run_vec(input int idx, input vec_t v);
        int   waited;
        logic got;
        @(posedge clk); #1;
        if (v.is_dm) begin
            bus.dm_req    = 1'b1;
            bus.dm_we     = v.we;
            bus.dm_funct3 = v.f3;
            bus.dm_addr   = v.addr;
            bus.dm_wdata  = v.wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 16) begin
            @(negedge clk);
            if (v.is_dm ? bus.dm_gnt : bus.if_gnt) got = 1'b1;
            else waited++;
        end
        chk($sformatf("v%0d_gnt", idx), {31'd0, got}, 32'd1);
        if (!got) begin
            drop_reqs();
            return;
        end
        chk($sformatf("v%0d_other_gnt", idx), {31'd0, v.is_dm ? bus.if_gnt : bus.dm_gnt}, 32'd0);
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        chk($sformatf("v%0d_w_en", idx), {28'd0, bus.sram_w_en}, {28'd0, v.exp_wen});
        chk($sformatf("v%0d_sram_addr", idx), {16'd0, bus.sram_addr}, {16'd0, v.addr});
        if (v.exp_wen != 4'b0000)
            chk($sformatf("v%0d_sram_wdata", idx), bus.sram_wdata, v.wdata);
        chk($sformatf("v%0d_rvalid_early", idx),
            {31'd0, v.is_dm ? bus.dm_rvalid : bus.if_rvalid}, 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_rvalid", idx), {31'd0, v.is_dm ? bus.dm_rvalid : bus.if_rvalid}, 32'd1);
        chk($sformatf("v%0d_rdata", idx), v.is_dm ? bus.dm_rdata : bus.if_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), {31'd0, v.is_dm ? bus.dm_err : bus.if_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk($sformatf("v%0d_rvalid_pulse", idx),
            {31'd0, v.is_dm ? bus.dm_rvalid : bus.if_rvalid}, 32'd0);
        chk($sformatf("v%0d_rdata_hold", idx), v.is_dm ? bus.dm_rdata : bus.if_rdata, v.exp_rdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_funct3 = 3'b000;
        bus.dm_addr = '0;  bus.dm_wdata = '0;

        // Basic store/load, byte lanes and extension
        add_dm(1'b1, 3'b010, 16'h0100, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        add_if(16'h0100, 32'hDEADBEEF, 1'b0);
        add_dm(1'b1, 3'b000, 16'h0101, 32'h0000007F, 4'b0001, 32'h0, 1'b0);
        add_dm(1'b0, 3'b000, 16'h0101, 32'h0, 4'b0000, 32'h0000007F, 1'b0);
        add_dm(1'b0, 3'b100, 16'h0101, 32'h0, 4'b0000, 32'h0000007F, 1'b0);
        add_dm(1'b0, 3'b001, 16'h0100, 32'h0, 4'b0000, 32'h00007FEF, 1'b0);
        add_dm(1'b1, 3'b000, 16'h0102, 32'h12345680, 4'b0001, 32'h0, 1'b0);
        add_dm(1'b0, 3'b000, 16'h0102, 32'h0, 4'b0000, 32'hFFFFFF80, 1'b0);
        add_dm(1'b0, 3'b100, 16'h0102, 32'h0, 4'b0000, 32'h00000080, 1'b0);
        add_dm(1'b0, 3'b010, 16'h0100, 32'h0, 4'b0000, 32'hDE807FEF, 1'b0);
        add_dm(1'b1, 3'b001, 16'h0104, 32'h1234ABCD, 4'b0011, 32'h0, 1'b0);
        add_dm(1'b0, 3'b001, 16'h0104, 32'h0, 4'b0000, 32'hFFFFABCD, 1'b0);
        add_dm(1'b0, 3'b101, 16'h0104, 32'h0, 4'b0000, 32'h0000ABCD, 1'b0);
        // Error cases around 0x0200
        add_dm(1'b1, 3'b010, 16'h0200, 32'h44332211, 4'b1111, 32'h0, 1'b0);
        add_dm(1'b1, 3'b010, 16'h0204, 32'h88776655, 4'b1111, 32'h0, 1'b0);
        add_dm(1'b0, 3'b001, 16'h0203, 32'h0, 4'b0000, 32'h0, 1'b1);
        add_dm(1'b1, 3'b010, 16'h0202, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1);
        add_dm(1'b0, 3'b011, 16'h0200, 32'h0, 4'b0000, 32'h0, 1'b1);
        add_dm(1'b1, 3'b100, 16'h0200, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1);
        add_dm(1'b0, 3'b101, 16'h0201, 32'h0, 4'b0000, 32'h0, 1'b1);
        add_dm(1'b0, 3'b010, 16'h0200, 32'h0, 4'b0000, 32'h44332211, 1'b0);
        add_dm(1'b0, 3'b010, 16'h0204, 32'h0, 4'b0000, 32'h88776655, 1'b0);
        add_dm(1'b0, 3'b001, 16'h0202, 32'h0, 4'b0000, 32'h00004433, 1'b0);
        add_dm(1'b0, 3'b000, 16'h0205, 32'h0, 4'b0000, 32'h00000066, 1'b0);
        add_dm(1'b0, 3'b000, 16'h0207, 32'h0, 4'b0000, 32'hFFFFFF88, 1'b0);
        // Instruction fetch alignment
        add_dm(1'b1, 3'b010, 16'h0008, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        add_if(16'h0006, 32'h0, 1'b1);
        add_if(16'h0008, 32'hCAFEF00D, 1'b0);
        add_dm(1'b1, 3'b010, 16'h0300, 32'h5A5A5A5A, 4'b1111, 32'h0, 1'b0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnts", {30'd0, bus.if_gnt, bus.dm_gnt}, 32'd0);
        chk("rst_rvalids", {30'd0, bus.if_rvalid, bus.dm_rvalid}, 32'd0);
        chk("rst_errs", {30'd0, bus.if_err, bus.dm_err}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        chk("rst_w_en", {28'd0, bus.sram_w_en}, 32'd0);
        chk("rst_sram_addr", {16'd0, bus.sram_addr}, 32'd0);
        chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
        chk("rst_state", {31'd0, bus.arb_state}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Both requesters held for 8 cycles straight after reset
        do_reset();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_funct3 = 3'b010; bus.dm_addr = 16'h0100;
        bus.if_req = 1'b1; bus.if_addr = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("tie_dm_gnt_c%0d", i), {31'd0, bus.dm_gnt}, {31'd0, (i % 4) == 0});
            chk($sformatf("tie_if_gnt_c%0d", i), {31'd0, bus.if_gnt}, {31'd0, (i % 4) == 2});
            chk($sformatf("tie_dm_rvalid_c%0d", i), {31'd0, bus.dm_rvalid}, {31'd0, (i % 4) == 2});
            chk($sformatf("tie_if_rvalid_c%0d", i), {31'd0, bus.if_rvalid},
                {31'd0, (i % 4) == 0 && i > 0});
            if ((i % 4) == 2) chk($sformatf("tie_dm_rdata_c%0d", i), bus.dm_rdata, 32'hDE807FEF);
            if ((i % 4) == 0 && i > 0) chk($sformatf("tie_if_rdata_c%0d", i), bus.if_rdata, 32'hDE807FEF);
        end
        @(posedge clk); #1;
        drop_reqs();
        @(negedge clk);
        chk("tie_if_rvalid_c8", {31'd0, bus.if_rvalid}, 32'd1);
        repeat (2) @(negedge clk);

        // Reset asserted during the ACCESS cycle of a store
        @(posedge clk); #1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_funct3 = 3'b010;
        bus.dm_addr = 16'h0300; bus.dm_wdata = 32'h11111111;
        @(negedge clk);
        chk("mid_rst_gnt", {31'd0, bus.dm_gnt}, 32'd1);
        @(posedge clk); #1;
        drop_reqs();
        chk("mid_rst_w_en_before", {28'd0, bus.sram_w_en}, 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en_after", {28'd0, bus.sram_w_en}, 32'd0);
        chk("mid_rst_state", {31'd0, bus.arb_state}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_no_rvalid_%0d", i), {31'd0, bus.dm_rvalid}, 32'd0);
        end
        chk("mid_rst_mem", {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]}, 32'h5A5A5A5A);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_funct3 = 3'b010; bus.dm_addr = 16'h0300;
        bus.if_req = 1'b1; bus.if_addr = 16'h0100;
        @(negedge clk);
        chk("post_rst_tie_dm_gnt", {31'd0, bus.dm_gnt}, 32'd1);
        chk("post_rst_tie_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
        @(posedge clk); #1;
        bus.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_dm_rvalid", {31'd0, bus.dm_rvalid}, 32'd1);
        chk("post_rst_dm_rdata", bus.dm_rdata, 32'h5A5A5A5A);
        chk("post_rst_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
        chk("post_rst_if_rdata", bus.if_rdata, 32'hDE807FEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
